// File: rtl/param_pipeline_core.sv
// Parametrised 4-stage in-order core (IF -> ID -> EX -> WB) with an instruction-memory load port
// and an IDLE/RUN/DRAIN/HALTED controller. Define PIPE_FWD_EN to forward WB into EX instead of stalling.
module param_pipeline_core #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int IMEM_AW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_we,
  input  logic [IMEM_AW-1:0]    imem_waddr,
  input  logic [2+3*REG_AW-1:0] imem_wdata,
  input  logic                  run,
  input  logic [REG_AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic [IMEM_AW-1:0]    pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  wb_valid,
  output logic [REG_AW-1:0]     wb_addr,
  output logic [DATA_W-1:0]     wb_data
);
  localparam int INSTR_W    = 2 + 3*REG_AW;
  localparam int NREG       = 2**REG_AW;
  localparam int IMEM_DEPTH = 2**IMEM_AW;
  localparam int IMM_W      = 2*REG_AW;

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_LDI = 2'b10, OP_HALT = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_e;

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    logic [DATA_W+IMM_W-1:0] wide;
    wide = {{DATA_W{1'b0}}, imm};
    return wide[DATA_W-1:0];
  endfunction

  // Modulo-2^DATA_W arithmetic; carries and borrows are simply dropped.
  function automatic logic [DATA_W-1:0] alu_wrap(input op_e op, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] imm);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_LDI:  r = imm;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e state, state_nxt;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  rf   [NREG];

  logic [INSTR_W-1:0] instr_p0;
  logic               vld_p0;

  op_e                op_id;
  logic [REG_AW-1:0]  rd_id, rs1_id, rs2_id;
  logic [IMM_W-1:0]   imm_id;
  logic [DATA_W-1:0]  a_id, b_id;
  logic               halt_id, stall, fetch_en, start;

  op_e                op_p1;
  logic [REG_AW-1:0]  rd_p1;
  logic [DATA_W-1:0]  a_p1, b_p1, imm_p1;
  logic               vld_p1, we_p1, halt_p1;
`ifdef PIPE_FWD_EN
  logic [REG_AW-1:0]  rs1_p1, rs2_p1;
`endif

  logic [DATA_W-1:0]  a_ex, b_ex, res_ex;

  logic [REG_AW-1:0]  rd_p2;
  logic [DATA_W-1:0]  res_p2;
  logic               vld_p2, we_p2, halt_p2, wr_en_p2;

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_RUN;
      S_RUN:    if (halt_id) state_nxt = S_DRAIN;
      S_DRAIN:  if (vld_p2 && halt_p2) state_nxt = S_HALTED;
      S_HALTED: if (run) state_nxt = S_RUN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign halted   = (state == S_HALTED);
  assign start    = run && ((state == S_IDLE) || (state == S_HALTED));
  assign fetch_en = (state == S_RUN) && !halt_id && !stall;

  // IF: fetch imem[pc] into IF/ID
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (start)         pc <= '0;
      else if (fetch_en) pc <= pc + 1'b1;
      if (halt_id)       vld_p0 <= 1'b0;
      else if (!stall)   vld_p0 <= fetch_en;
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_en) instr_p0 <= imem[pc];
  end

  // ID: decode and operand read with WB write-through
  assign op_id   = op_e'(instr_p0[INSTR_W-1 -: 2]);
  assign rd_id   = instr_p0[3*REG_AW-1 -: REG_AW];
  assign rs1_id  = instr_p0[2*REG_AW-1 -: REG_AW];
  assign rs2_id  = instr_p0[REG_AW-1:0];
  assign imm_id  = instr_p0[IMM_W-1:0];
  assign halt_id = vld_p0 && (op_id == OP_HALT);

  assign wr_en_p2 = vld_p2 && we_p2;
  assign a_id     = (wr_en_p2 && (rd_p2 == rs1_id)) ? res_p2 : rf[rs1_id];
  assign b_id     = (wr_en_p2 && (rd_p2 == rs2_id)) ? res_p2 : rf[rs2_id];

`ifdef PIPE_FWD_EN
  assign stall = 1'b0;
`else
  logic uses_src_id;
  assign uses_src_id = (op_id == OP_ADD) || (op_id == OP_SUB);
  // Distance-1 RAW: the producer is still in EX, so hold ID one cycle until write-through covers it.
  assign stall = vld_p0 && uses_src_id && vld_p1 && we_p1 &&
                 ((rd_p1 == rs1_id) || (rd_p1 == rs2_id));
`endif

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0 && !stall;
  end

  always_ff @(posedge clk) begin
    op_p1  <= op_id;
    rd_p1  <= rd_id;
    a_p1   <= a_id;
    b_p1   <= b_id;
    imm_p1 <= zext_imm(imm_id);
`ifdef PIPE_FWD_EN
    rs1_p1 <= rs1_id;
    rs2_p1 <= rs2_id;
`endif
  end

  // EX: operand select and ALU
  assign we_p1   = (op_p1 != OP_HALT);
  assign halt_p1 = (op_p1 == OP_HALT);

`ifdef PIPE_FWD_EN
  assign a_ex = (wr_en_p2 && (rd_p2 == rs1_p1)) ? res_p2 : a_p1;
  assign b_ex = (wr_en_p2 && (rd_p2 == rs2_p1)) ? res_p2 : b_p1;
`else
  assign a_ex = a_p1;
  assign b_ex = b_p1;
`endif

  assign res_ex = alu_wrap(op_p1, a_ex, b_ex, imm_p1);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      we_p2   <= 1'b0;
      halt_p2 <= 1'b0;
      rd_p2   <= '0;
      res_p2  <= '0;
    end else begin
      vld_p2  <= vld_p1;
      we_p2   <= we_p1;
      halt_p2 <= halt_p1;
      rd_p2   <= rd_p1;
      res_p2  <= res_ex;
    end
  end

  // WB: commit into the register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= DATA_W'(i);
    end else if (wr_en_p2) begin
      rf[rd_p2] <= res_p2;
    end
  end

  assign wb_valid  = wr_en_p2;
  assign wb_addr   = rd_p2;
  assign wb_data   = res_p2;
  assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: tb/tb_param_pipeline_core.sv
// Directed bench for param_pipeline_core (DATA_W=8, REG_AW=3, IMEM_AW=4) with hand-computed expectations.
module tb_param_pipeline_core;
  localparam int DATA_W  = 8;
  localparam int REG_AW  = 3;
  localparam int IMEM_AW = 4;
  localparam int INSTR_W = 2 + 3*REG_AW;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               imem_we = 1'b0;
  logic [IMEM_AW-1:0] imem_waddr = '0;
  logic [INSTR_W-1:0] imem_wdata = '0;
  logic               run = 1'b0;
  logic [REG_AW-1:0]  dbg_raddr = '0;
  logic [DATA_W-1:0]  dbg_rdata;
  logic [IMEM_AW-1:0] pc;
  logic               busy, halted, wb_valid;
  logic [REG_AW-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  param_pipeline_core #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .run(run), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .pc(pc), .busy(busy), .halted(halted), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [REG_AW-1:0] cm_addr [$];
  logic [DATA_W-1:0] cm_data [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] ldi(input int rd, input int imm);
    logic [2:0] r;
    logic [5:0] v;
    r = rd[2:0];
    v = imm[5:0];
    return {2'b10, r, v};
  endfunction

  function automatic logic [INSTR_W-1:0] alu(input logic [1:0] op, input int rd, input int rs1,
                                             input int rs2);
    logic [2:0] d, s1, s2;
    d = rd[2:0]; s1 = rs1[2:0]; s2 = rs2[2:0];
    return {op, d, s1, s2};
  endfunction

  localparam logic [INSTR_W-1:0] HALT = {2'b11, 9'd0};

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      cm_addr.push_back(wb_addr);
      cm_data.push_back(wb_data);
    end
  endtask

  task automatic load(input int a, input logic [INSTR_W-1:0] d);
    imem_we    = 1'b1;
    imem_waddr = IMEM_AW'(a);
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic pulse_run();
    cm_addr.delete();
    cm_data.delete();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic run_to_halt(input int max, output int cyc);
    pulse_run();
    cyc = 0;
    while (halted !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_reg(input string tag, input int r, input int exp);
    dbg_raddr = REG_AW'(r);
    #1;
    chk(tag, 32'(dbg_rdata), 32'(exp));
  endtask

  int cyc, exp_cyc, n5, k, prev_pc;
  logic wrap;
  logic [31:0] found;
  logic [DATA_W-1:0] r3_vals [$];

  initial begin
`ifdef PIPE_FWD_EN
    exp_cyc = 7;
`else
    exp_cyc = 8;
`endif
    // Test 1: reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("t1_busy", 32'(busy), 0);
    chk("t1_halted", 32'(halted), 0);
    chk("t1_wb_valid", 32'(wb_valid), 0);
    chk("t1_pc", 32'(pc), 0);
    chk("t1_wb_addr", 32'(wb_addr), 0);
    chk("t1_wb_data", 32'(wb_data), 0);
    for (int i = 0; i < 8; i++) chk_reg($sformatf("t1_r%0d", i), i, i);

    // Test 2: ADD with distance-1 and distance-2 dependencies
    load(0, ldi(1, 5)); load(1, ldi(2, 3)); load(2, alu(2'b00, 3, 1, 2)); load(3, HALT);
    for (int i = 4; i < 16; i++) load(i, HALT);
    run_to_halt(40, cyc);
    chk("t2_halted", 32'(halted), 1);
    chk("t2_cycles", 32'(cyc), 32'(exp_cyc));
    chk("t2_busy", 32'(busy), 0);
    chk("t2_ncommit", 32'(cm_data.size()), 3);
    chk_reg("t2_r3", 3, 8);
    chk_reg("t2_r1", 1, 5);

    // Test 3: SUB wraps below zero
    load(0, ldi(1, 3)); load(1, ldi(2, 5)); load(2, alu(2'b01, 4, 1, 2)); load(3, HALT);
    run_to_halt(40, cyc);
    chk("t3_halted", 32'(halted), 1);
    chk("t3_cycles", 32'(cyc), 32'(exp_cyc));
    found = 32'hDEAD;
    foreach (cm_addr[i]) if (cm_addr[i] == 3'd4) found = 32'(cm_data[i]);
    chk("t3_wb_r4", found, 32'hFE);
    chk_reg("t3_r4", 4, 8'hFE);

    // Test 4: instruction after HALT never commits; rerun starts from pc=0
    load(0, ldi(6, 9)); load(1, HALT); load(2, alu(2'b00, 5, 5, 5));
    run_to_halt(40, cyc);
    chk("t4_cycles", 32'(cyc), 5);
    chk("t4_pc_frozen", 32'(pc), 2);
    n5 = 0;
    foreach (cm_addr[i]) if (cm_addr[i] == 3'd5) n5++;
    chk("t4_no_r5_commit", 32'(n5), 0);
    chk("t4_ncommit", 32'(cm_data.size()), 1);
    chk_reg("t4_r5", 5, 5);
    chk_reg("t4_r6", 6, 9);
    load(0, ldi(6, 17));
    run_to_halt(40, cyc);
    chk("t4b_halted", 32'(halted), 1);
    chk("t4b_cycles", 32'(cyc), 5);
    chk_reg("t4b_r6", 6, 17);
    chk_reg("t4b_r5", 5, 5);

    // Test 5: endless LDI stream wraps pc; reset mid-stream
    for (int i = 0; i < 16; i++) load(i, ldi(i % 8, i + 32));
    pulse_run();
    wrap = 1'b0;
    prev_pc = int'(pc);
    for (int i = 0; i < 24; i++) begin
      tick();
      if (prev_pc == 15 && pc == 4'd0) wrap = 1'b1;
      prev_pc = int'(pc);
    end
    chk("t5_pc_wrap", 32'(wrap), 1);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_ncommit_ge17", 32'(cm_data.size() >= 17), 1);
    if (cm_data.size() >= 17) begin
      chk("t5_c0_data", 32'(cm_data[0]), 32);
      chk("t5_c15_addr", 32'(cm_addr[15]), 7);
      chk("t5_c15_data", 32'(cm_data[15]), 47);
      chk("t5_c16_addr", 32'(cm_addr[16]), 0);
      chk("t5_c16_data", 32'(cm_data[16]), 32);
    end
    reset = 1'b1;
    tick();
    chk("t5_rst_wb_valid", 32'(wb_valid), 0);
    chk("t5_rst_pc", 32'(pc), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_halted", 32'(halted), 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) chk_reg($sformatf("t5_rst_r%0d", i), i, i);
    chk("t5_idle_pc", 32'(pc), 0);

    // Test 6: imem write colliding with the fetch of the same address
    pulse_run();
    k = 0;
    while (pc !== 4'd3 && k < 10) begin
      tick();
      k++;
    end
    chk("t6_reach_pc3", 32'(pc), 3);
    imem_we    = 1'b1;
    imem_waddr = 4'd3;
    imem_wdata = ldi(3, 60);
    tick();
    imem_we    = 1'b0;
    repeat (30) tick();
    foreach (cm_addr[i]) if (cm_addr[i] == 3'd3) r3_vals.push_back(cm_data[i]);
    chk("t6_n_r3_ge3", 32'(r3_vals.size() >= 3), 1);
    if (r3_vals.size() >= 3) begin
      chk("t6_old_instr", 32'(r3_vals[0]), 35);
      chk("t6_imem11", 32'(r3_vals[1]), 43);
      chk("t6_new_instr", 32'(r3_vals[2]), 60);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_pipeline_core.md
Name: param_pipeline_core

Overview:
- Parametrised 4-stage in-order core: IF -> ID -> EX -> WB.
- Generalises the team's fixed 8-bit/8-register pipeline to configurable data width, register count and instruction-memory depth.
- Adds what the fixed pipeline lacks: a real program counter, instruction-memory load port, register writeback, RAW hazard handling, and a run/halt state machine.
- Used as the compute tile under the test harness; the harness loads programs through the imem write port.

Parameters:
- DATA_W, 8: datapath and register width.
- REG_AW, 3: register address width; NREG = 2^REG_AW.
- IMEM_AW, 4: instruction address width; IMEM_DEPTH = 2^IMEM_AW.
- Derived (localparam): INSTR_W = 2 + 3*REG_AW. Fields: [op 2][rd][rs1][rs2].

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_we  in  1  instruction memory write strobe.
- imem_waddr  in  IMEM_AW  write address.
- imem_wdata  in  INSTR_W  write data.
- run  in  1  start pulse; honoured in IDLE or HALTED only.
- dbg_raddr  in  REG_AW  debug register read address.
- dbg_rdata  out  DATA_W  combinational read of reg[dbg_raddr].
- pc  out  IMEM_AW  current fetch address.
- busy  out  1  high in RUN or DRAIN.
- halted  out  1  high in HALTED.
- wb_valid  out  1  WB stage holds a committing instruction.
- wb_addr  out  REG_AW  destination of committing instruction.
- wb_data  out  DATA_W  result being committed.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-high.
- Reset values:
  - state=IDLE; pc=0; all stage valids=0.
  - busy=0, halted=0, wb_valid=0, wb_addr=0, wb_data=0.
  - reg[i] = i mod 2^DATA_W.
  - imem is not reset.
  - Reset asserted mid-run aborts all in-flight instructions the same edge. No writeback occurs on that edge.
- Opcodes:
  - 00 ADD: rd = rs1 + rs2.
  - 01 SUB: rd = rs1 - rs2.
  - 10 LDI: rd = zero-extended {rs1,rs2} field (2*REG_AW bits).
  - 11 HALT: no writeback.
  - All arithmetic is modulo 2^DATA_W; no flags.
- Stages:
  - IF: combinational imem[pc] registered into IF/ID with a valid bit.
  - ID: reads operands, with write-through: a same-cycle WB to the same register returns the new value.
  - EX: computes the result.
  - WB: drives wb_* and writes reg[rd] at the next edge.
- Latency: an instruction fetched at edge N is on wb_* in the cycle after edge N+2 and committed at edge N+3. Throughput is 1/cycle without stalls.
- PC: increments per fetch; wraps IMEM_DEPTH-1 -> 0.
- imem write: same address/cycle as a fetch returns the old data; the new data is visible next cycle.
- FSM:
  - IDLE --run--> RUN: pc=0, first fetch at next edge.
  - RUN --HALT decoded in ID--> DRAIN: IF/ID invalidated, fetch stops, pc frozen.
  - DRAIN --HALT reaches WB--> HALTED (halted=1 next edge).
  - HALTED --run--> RUN from pc=0. Register contents are preserved.
  - run in RUN/DRAIN is ignored.
- Hazards: distance-2 RAW is covered by the write-through; distance-1 RAW (ID source = EX rd, EX valid and writing) is handled per the Optional Feature.
- Write-through is never disabled.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined:
  - The WB result is forwarded into the EX operand mux when the WB rd matches the EX rs1/rs2 and WB is valid and writing.
  - Never stalls.
- Undefined:
  - No forwarding. A distance-1 RAW stalls.
  - On a stall: hold pc and IF/ID, insert a bubble into EX (valid=0), 1 cycle per hazard.
  - Results are identical either way; only the cycle count differs.

Test Plan (DATA_W=8, REG_AW=3, IMEM_AW=4):
1. Reset, no run -> busy=0, halted=0, wb_valid=0, pc=0; dbg_rdata for r0..r7 reads 0..7.
2. Load LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT; pulse run -> r3=8, halted=1. Cycles from run to halted: 7 with PIPE_FWD_EN, 8 without.
3. LDI r1,3; LDI r2,5; SUB r4,r1,r2; HALT -> r4=0xFE; wb_data=0xFE on r4's commit cycle.
4. HALT at imem[1] with ADD r5,r5,r5 at imem[2] -> r5 stays 5; no wb_valid for imem[2]. A second run pulse re-executes from pc=0.
5. 16 LDIs with no HALT; observe pc -> pc wraps 15->0 and the imem[0] LDI commits again. Assert reset mid-stream -> next cycle wb_valid=0, pc=0, IDLE, r0..r7 back to 0..7.
6. Write imem[3] while running at pc=3 in the same cycle -> the old instruction executes; the new one executes on the next wrap.
